// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP control unit: opcode encodings, accumulator
// and ALU operand mux encodings, ALU operation codes and the RUN/HALT state
// encoding. Imported by bip_opcode_decoder and bip_control_unit.
// -----------------------------------------------------------------------------
package bip_pkg;

  // Opcode encodings (5-bit native width; zero-extended where wider)
  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;
  localparam logic [4:0] OPC_BEQ  = 5'b01000;
  localparam logic [4:0] OPC_BNE  = 5'b01001;
  localparam logic [4:0] OPC_BLT  = 5'b01010;
  localparam logic [4:0] OPC_JMP  = 5'b01011;
  localparam logic [4:0] OPC_CALL = 5'b01100;
  localparam logic [4:0] OPC_RET  = 5'b01101;

  // Accumulator input mux
  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // ALU B operand mux
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // ALU operation
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } bip_state_e;

endpackage

// File: rtl/bip_opcode_decoder.sv
// -----------------------------------------------------------------------------
// bip_opcode_decoder
// Purely combinational opcode decode into datapath controls. Strobes are raw
// decode; the top gates them with stall/halt/reset.
// Ports:
//   opcode     in   OPCODE_WIDTH  opcode field of the current instruction
//   sel_a      out  2             accumulator mux select
//   sel_b      out  1             ALU B select
//   wr_acc     out  1             accumulator write (ungated)
//   op         out  1             ALU op: 0 add, 1 subtract
//   wr_ram     out  1             data RAM write (ungated)
//   rd_ram     out  1             data RAM read (ungated)
//   is_branch  out  1             JMP/BEQ/BNE/BLT
//   is_halt    out  1             HLT
// CALL/RET are not decoded here; the top handles them when the call stack
// is built in.
// -----------------------------------------------------------------------------
module bip_opcode_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic                    wr_acc,
  output logic                    op,
  output logic                    wr_ram,
  output logic                    rd_ram,
  output logic                    is_branch,
  output logic                    is_halt
);

  always_comb begin
    sel_a     = SEL_A_RAM;
    sel_b     = SEL_B_RAM;
    wr_acc    = 1'b0;
    op        = ALU_ADD;
    wr_ram    = 1'b0;
    rd_ram    = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OPCODE_WIDTH'(OPC_HLT):  is_halt = 1'b1;
      OPCODE_WIDTH'(OPC_STO):  wr_ram  = 1'b1;
      OPCODE_WIDTH'(OPC_LD): begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        sel_a  = SEL_A_RAM;
      end
      OPCODE_WIDTH'(OPC_LDI): begin
        wr_acc = 1'b1;
        sel_a  = SEL_A_IMM;
      end
      OPCODE_WIDTH'(OPC_ADD): begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        sel_a  = SEL_A_ALU;
        sel_b  = SEL_B_RAM;
        op     = ALU_ADD;
      end
      OPCODE_WIDTH'(OPC_ADDI): begin
        wr_acc = 1'b1;
        sel_a  = SEL_A_ALU;
        sel_b  = SEL_B_IMM;
        op     = ALU_ADD;
      end
      OPCODE_WIDTH'(OPC_SUB): begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
        sel_a  = SEL_A_ALU;
        sel_b  = SEL_B_RAM;
        op     = ALU_SUB;
      end
      OPCODE_WIDTH'(OPC_SUBI): begin
        wr_acc = 1'b1;
        sel_a  = SEL_A_ALU;
        sel_b  = SEL_B_IMM;
        op     = ALU_SUB;
      end
      OPCODE_WIDTH'(OPC_BEQ),
      OPCODE_WIDTH'(OPC_BNE),
      OPCODE_WIDTH'(OPC_BLT),
      OPCODE_WIDTH'(OPC_JMP):  is_branch = 1'b1;
      default: ;  // NOP
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
// BIP control unit: program counter, RUN/HALT sequencing, branch resolution
// and opcode decode. Optional call/return stack enabled by defining the macro
// BIP_CALL_STACK_EN; without it CALL/RET behave as NOP and no stack exists.
// Ports:
//   clk             in   1              rising-edge clock
//   rst             in   1              synchronous, active-low reset
//   instruction     in   OPC+OPR        instruction from program ROM
//   stall           in   1              freeze PC/state/stack, kill strobes
//   acc_zero        in   1              accumulator == 0
//   acc_neg         in   1              accumulator sign
//   program_counter out  PC_WIDTH       registered fetch address
//   operand         out  OPERAND_WIDTH  instruction operand pass-through
//   sel_a           out  2              acc mux: 00 RAM, 01 imm, 10 ALU
//   sel_b           out  1              ALU B: 0 RAM, 1 imm
//   wr_acc          out  1              accumulator write enable
//   op              out  1              ALU op: 0 add, 1 subtract
//   wr_ram          out  1              data RAM write strobe
//   rd_ram          out  1              data RAM read strobe
//   halted          out  1              registered, 1 in HALT
//   state_dbg       out  bip_state_e    current FSM state (debug)
// Handshake: none; the unit advances every cycle that stall is low.
// -----------------------------------------------------------------------------
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int STACK_DEPTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instruction,
  input  logic                                  stall,
  input  logic                                  acc_zero,
  input  logic                                  acc_neg,
  output logic [PC_WIDTH-1:0]                   program_counter,
  output logic [OPERAND_WIDTH-1:0]              operand,
  output logic [1:0]                            sel_a,
  output logic                                  sel_b,
  output logic                                  wr_acc,
  output logic                                  op,
  output logic                                  wr_ram,
  output logic                                  rd_ram,
  output logic                                  halted,
  output bip_state_e                            state_dbg
);

  localparam int INSTR_W = OPCODE_WIDTH + OPERAND_WIDTH;

  if (STACK_DEPTH < 1 || OPERAND_WIDTH < PC_WIDTH) begin : g_bad_params
    $error("bip_control_unit: STACK_DEPTH must be >= 1 and OPERAND_WIDTH >= PC_WIDTH");
  end

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [PC_WIDTH-1:0]     target;
  logic [PC_WIDTH-1:0]     pc_inc;
  logic [PC_WIDTH-1:0]     pc_d;
  bip_state_e              state_q, state_d;

  logic dec_wr_acc, dec_wr_ram, dec_rd_ram, is_branch, is_halt;
  logic take_branch, strobe_en;

  assign opcode  = instruction[INSTR_W-1 -: OPCODE_WIDTH];
  assign operand = instruction[OPERAND_WIDTH-1:0];
  assign target  = operand[PC_WIDTH-1:0];
  assign pc_inc  = program_counter + PC_WIDTH'(1);  // natural wrap at all-ones

  bip_opcode_decoder #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_decoder (
    .opcode    (opcode),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .wr_acc    (dec_wr_acc),
    .op        (op),
    .wr_ram    (dec_wr_ram),
    .rd_ram    (dec_rd_ram),
    .is_branch (is_branch),
    .is_halt   (is_halt)
  );

  // Side-effecting strobes only fire while actually executing.
  assign strobe_en = rst && !stall && (state_q == ST_RUN);
  assign wr_acc    = dec_wr_acc && strobe_en;
  assign wr_ram    = dec_wr_ram && strobe_en;
  assign rd_ram    = dec_rd_ram && strobe_en;

  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

  // Flags are sampled alongside the branch instruction itself.
  always_comb begin
    take_branch = 1'b0;
    if (is_branch) begin
      case (opcode)
        OPCODE_WIDTH'(OPC_JMP): take_branch = 1'b1;
        OPCODE_WIDTH'(OPC_BEQ): take_branch = acc_zero;
        OPCODE_WIDTH'(OPC_BNE): take_branch = !acc_zero;
        OPCODE_WIDTH'(OPC_BLT): take_branch = acc_neg;
        default:                take_branch = 1'b0;
      endcase
    end
  end

`ifdef BIP_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q;
  logic                push, pop;
  logic                is_call, is_ret, stack_full, stack_empty;
  logic [PC_WIDTH-1:0] stack_top;

  assign is_call     = (opcode == OPCODE_WIDTH'(OPC_CALL));
  assign is_ret      = (opcode == OPCODE_WIDTH'(OPC_RET));
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign stack_top   = stack_mem[IDX_W'(sp_q - SP_W'(1))];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= '0;
    end else if (push) begin
      stack_mem[IDX_W'(sp_q)] <= pc_inc;
      sp_q                    <= sp_q + SP_W'(1);
    end else if (pop) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end
`endif

  // Next-state / next-PC. Stall freezes everything; a stack fault holds PC
  // and parks the unit in HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = program_counter;
`ifdef BIP_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    if (state_q == ST_RUN && !stall) begin
      if (is_halt) begin
        state_d = ST_HALT;
`ifdef BIP_CALL_STACK_EN
      end else if (is_call) begin
        if (stack_full) begin
          state_d = ST_HALT;
        end else begin
          push = 1'b1;
          pc_d = target;
        end
      end else if (is_ret) begin
        if (stack_empty) begin
          state_d = ST_HALT;
        end else begin
          pop  = 1'b1;
          pc_d = stack_top;
        end
`endif
      end else if (take_branch) begin
        pc_d = target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      program_counter <= '0;
    end else begin
      state_q         <= state_d;
      program_counter <= pc_d;
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_control_unit
// Directed test of bip_control_unit: reset, increment, 4-bit PC wrap (second
// instance), branches, decode strobes, stall, HALT, and call/return
// (BIP_CALL_STACK_EN) or CALL/RET-as-NOP (default build).
// -----------------------------------------------------------------------------
module tb_bip_control_unit;
  import bip_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] instruction = 16'h0000;
  logic        stall       = 1'b0;
  logic        acc_zero    = 1'b0;
  logic        acc_neg     = 1'b0;

  logic [10:0] program_counter, operand;
  logic [1:0]  sel_a;
  logic        sel_b, wr_acc, op, wr_ram, rd_ram, halted;
  bip_state_e  state_dbg;

  bip_control_unit u_dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .stall           (stall),
    .acc_zero        (acc_zero),
    .acc_neg         (acc_neg),
    .program_counter (program_counter),
    .operand         (operand),
    .sel_a           (sel_a),
    .sel_b           (sel_b),
    .wr_acc          (wr_acc),
    .op              (op),
    .wr_ram          (wr_ram),
    .rd_ram          (rd_ram),
    .halted          (halted),
    .state_dbg       (state_dbg)
  );

  // Narrow-PC instance, fed NOPs forever, for the wrap check
  logic [15:0] nop_instr = 16'hF800;
  logic [3:0]  pc4;
  logic [10:0] operand4;
  logic [1:0]  sel_a4;
  logic        sel_b4, wr_acc4, op4, wr_ram4, rd_ram4, halted4;
  bip_state_e  state_dbg4;

  bip_control_unit #(.PC_WIDTH(4)) u_dut4 (
    .clk             (clk),
    .rst             (rst),
    .instruction     (nop_instr),
    .stall           (1'b0),
    .acc_zero        (1'b0),
    .acc_neg         (1'b0),
    .program_counter (pc4),
    .operand         (operand4),
    .sel_a           (sel_a4),
    .sel_b           (sel_b4),
    .wr_acc          (wr_acc4),
    .op              (op4),
    .wr_ram          (wr_ram4),
    .rd_ram          (rd_ram4),
    .halted          (halted4),
    .state_dbg       (state_dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opr);
    return {opc, opr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles while ADD is presented
    instruction = mk(OPC_ADD, 11'h000);
    step();
    step();
    check("rst_pc", program_counter, 32'h0);
    check("rst_halted", halted, 32'h0);
    check("rst_wr_acc", wr_acc, 32'h0);
    check("rst_state", state_dbg, ST_RUN);
    rst = 1'b1;
    settle();
    check("post_rst_wr_acc", wr_acc, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc_pc", program_counter, i);
    end

    // 4-bit wrap: 17 increments from 0 must pass 15 -> 0
    do_reset();
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i % 16));
    for (int i = 1; i <= 17; i++) begin
      step();
      check("wrap_pc4", pc4, exp_q.pop_front());
      check("wrap_halted4", halted4, 32'h0);
    end

    // Branches (main PC currently 17 after reset + 17 ADDs)
    instruction = mk(OPC_BEQ, 11'h020); acc_zero = 1'b1;
    step(); check("beq_taken", program_counter, 32'h020);
    acc_zero = 1'b0;
    step(); check("beq_not_taken", program_counter, 32'h021);
    instruction = mk(OPC_JMP, 11'h7FF);
    step(); check("jmp_7ff", program_counter, 32'h7FF);
    instruction = mk(5'b11111, 11'h000);
    step(); check("wrap11_pc", program_counter, 32'h000);
    instruction = mk(OPC_BLT, 11'h055); acc_neg = 1'b1;
    step(); check("blt_taken", program_counter, 32'h055);
    acc_neg = 1'b0;
    step(); check("blt_not_taken", program_counter, 32'h056);
    instruction = mk(OPC_BNE, 11'h123); acc_zero = 1'b0;
    step(); check("bne_taken", program_counter, 32'h123);
    acc_zero = 1'b1;
    step(); check("bne_not_taken", program_counter, 32'h124);
    acc_zero = 1'b0;

    // Decode spot checks (no clock edge)
    instruction = mk(OPC_LDI, 11'h05A); settle();
    check("ldi_sel_a", sel_a, 32'h1);
    check("ldi_wr_acc", wr_acc, 32'h1);
    check("ldi_rd_ram", rd_ram, 32'h0);
    check("ldi_operand", operand, 32'h05A);
    instruction = mk(OPC_SUB, 11'h003); settle();
    check("sub_op", op, 32'h1);
    check("sub_sel_a", sel_a, 32'h2);
    check("sub_rd_ram", rd_ram, 32'h1);
    instruction = mk(OPC_STO, 11'h003); settle();
    check("sto_wr_ram", wr_ram, 32'h1);
    check("sto_wr_acc", wr_acc, 32'h0);
    instruction = mk(OPC_SUBI, 11'h003); settle();
    check("subi_sel_b", sel_b, 32'h1);
    check("subi_op", op, 32'h1);

    // Stall on ADDI
    instruction = mk(OPC_ADDI, 11'h003); stall = 1'b1; settle();
    check("stall_wr_acc", wr_acc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", program_counter, 32'h124);
      check("stall_wr_acc_hold", wr_acc, 32'h0);
    end
    stall = 1'b0; settle();
    check("unstall_wr_acc", wr_acc, 32'h1);
    step();
    check("unstall_pc", program_counter, 32'h125);
    instruction = mk(5'b11111, 11'h000); settle();
    check("nop_wr_acc", wr_acc, 32'h0);

    // Stall outranks HLT
    instruction = mk(OPC_HLT, 11'h000); stall = 1'b1;
    step();
    check("stall_hlt_halted", halted, 32'h0);
    check("stall_hlt_pc", program_counter, 32'h125);
    stall = 1'b0;

    // HLT at PC=5
    instruction = mk(OPC_JMP, 11'h005);
    step(); check("jmp_5", program_counter, 32'h005);
    instruction = mk(OPC_HLT, 11'h000); settle();
    check("hlt_not_yet", halted, 32'h0);
    step();
    check("hlt_halted", halted, 32'h1);
    check("hlt_pc", program_counter, 32'h005);
    check("hlt_state", state_dbg, ST_HALT);
    instruction = mk(OPC_ADD, 11'h001);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_pc", program_counter, 32'h005);
      check("halt_halted", halted, 32'h1);
      check("halt_strobes", {wr_acc, wr_ram, rd_ram}, 32'h0);
    end
    rst = 1'b0;
    step();
    check("halt_rst_pc", program_counter, 32'h0);
    check("halt_rst_halted", halted, 32'h0);
    rst = 1'b1;

    // CALL / RET
    instruction = mk(OPC_JMP, 11'h009);
    step(); check("jmp_9", program_counter, 32'h009);
    instruction = mk(OPC_CALL, 11'h100);
`ifdef BIP_CALL_STACK_EN
    step(); check("call_pc", program_counter, 32'h100);
    instruction = mk(OPC_RET, 11'h000);
    step(); check("ret_pc", program_counter, 32'h00A);
    check("ret_halted", halted, 32'h0);

    // Overflow: four nested calls fit, the fifth halts with PC held
    do_reset();
    instruction = mk(OPC_CALL, 11'h200);
    for (int i = 0; i < 4; i++) begin
      step();
      check("nest_pc", program_counter, 32'h200);
      check("nest_halted", halted, 32'h0);
    end
    step();
    check("ovf_pc", program_counter, 32'h200);
    check("ovf_halted", halted, 32'h1);

    // Underflow: RET on empty stack halts with PC held
    do_reset();
    instruction = mk(OPC_RET, 11'h000);
    step();
    check("udf_pc", program_counter, 32'h000);
    check("udf_halted", halted, 32'h1);
    do_reset();
`else
    step(); check("call_nop_pc", program_counter, 32'h00A);
    instruction = mk(OPC_RET, 11'h000);
    step(); check("ret_nop_pc", program_counter, 32'h00B);
    check("ret_nop_halted", halted, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
